// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard.
// master = decode stage, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int LW     = $clog2(DEPTH),
    parameter int SW     = $clog2(DEPTH + 1),
    parameter int CNT_W  = 16
);
    logic              i_HSB_issue;
    logic              i_HSB_we;
    logic [REG_AW-1:0] i_HSB_wa;
    logic [LW-1:0]     i_HSB_lat;
    logic [REG_AW-1:0] i_HSB_ra0;
    logic [REG_AW-1:0] i_HSB_ra1;
    logic              i_HSB_use0;
    logic              i_HSB_use1;
    logic              i_HSB_flush;
    logic              o_HSB_stall;
    logic [SW-1:0]     o_HSB_fwd0;
    logic [SW-1:0]     o_HSB_fwd1;
    logic [DEPTH-1:0]  o_HSB_vld;
    logic [CNT_W-1:0]  o_HSB_stall_cnt;

    modport master (
        output i_HSB_issue, i_HSB_we, i_HSB_wa, i_HSB_lat,
        output i_HSB_ra0, i_HSB_ra1, i_HSB_use0, i_HSB_use1,
        output i_HSB_flush,
        input  o_HSB_stall, o_HSB_fwd0, o_HSB_fwd1,
        input  o_HSB_vld, o_HSB_stall_cnt
    );

    modport slave (
        input  i_HSB_issue, i_HSB_we, i_HSB_wa, i_HSB_lat,
        input  i_HSB_ra0, i_HSB_ra1, i_HSB_use0, i_HSB_use1,
        input  i_HSB_flush,
        output o_HSB_stall, o_HSB_fwd0, o_HSB_fwd1,
        output o_HSB_vld, o_HSB_stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight register writes (entry 0 = EXE).
// Ports: clk, rstn (async low), bus = decode-side bundle (slave):
//   issue/we/wa/lat/ra0/ra1/use0/use1/flush in; stall/fwd0/fwd1/vld/stall_cnt out.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int LW     = $clog2(DEPTH),
    parameter int SW     = $clog2(DEPTH + 1),
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [LW-1:0]     lat;
    } ent_t;

    ent_t             r_e [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic             w_stall;
    logic             w_ins;
    logic [LW-1:0]    w_lat;
    ent_t             w_new;
    logic [DEPTH-1:0] w_vld;

    logic [REG_AW-1:0] w_ra  [2];
    logic              w_use [2];

    assign w_ra[0]  = bus.i_HSB_ra0;
    assign w_ra[1]  = bus.i_HSB_ra1;
    assign w_use[0] = bus.i_HSB_use0;
    assign w_use[1] = bus.i_HSB_use1;

    // Scan oldest to youngest so the youngest matching writer wins.
    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [SW-1:0] fwd;
        logic          haz;
        always_comb begin
            fwd = '0;
            haz = 1'b0;
            if (w_use[s] && (w_ra[s] != '0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_e[k].v && r_e[k].we && (r_e[k].wa == w_ra[s])) begin
                        if (k >= int'(r_e[k].lat)) begin
                            fwd = SW'(k + 1);
                            haz = 1'b0;
                        end else begin
                            fwd = '0;
                            haz = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_stall = bus.i_HSB_issue && !bus.i_HSB_flush &&
                     (g_src[0].haz || g_src[1].haz);
    assign w_ins   = bus.i_HSB_issue && !w_stall && !bus.i_HSB_flush;

    // A result can never arrive later than the last tracked stage.
    assign w_lat = (int'(bus.i_HSB_lat) >= DEPTH) ? LW'(DEPTH - 1) : bus.i_HSB_lat;

    always_comb begin
        w_new     = '0;
        w_new.v   = w_ins;
        w_new.we  = bus.i_HSB_we;
        w_new.wa  = bus.i_HSB_wa;
        w_new.lat = w_lat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_e[k] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_e[0] <= w_new;
            for (int k = 1; k < DEPTH; k++) begin
                r_e[k] <= r_e[k-1];
            end
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_vld[k] = r_e[k].v;
        end
    end

    assign bus.o_HSB_stall     = w_stall;
    assign bus.o_HSB_fwd0      = g_src[0].fwd;
    assign bus.o_HSB_fwd1      = g_src[1].fwd;
    assign bus.o_HSB_vld       = w_vld;
    assign bus.o_HSB_stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed steps then random traffic
// against a queue-based model; a CNT_W=2 copy checks counter saturation.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic clk;
    logic rstn;

    hazard_scoreboard_if #(.DEPTH(DEPTH)) b1 ();
    hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(2)) b2 ();

    hazard_scoreboard #(.DEPTH(DEPTH)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b1)
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b2)
    );

    assign b2.i_HSB_issue = b1.i_HSB_issue;
    assign b2.i_HSB_we    = b1.i_HSB_we;
    assign b2.i_HSB_wa    = b1.i_HSB_wa;
    assign b2.i_HSB_lat   = b1.i_HSB_lat;
    assign b2.i_HSB_ra0   = b1.i_HSB_ra0;
    assign b2.i_HSB_ra1   = b1.i_HSB_ra1;
    assign b2.i_HSB_use0  = b1.i_HSB_use0;
    assign b2.i_HSB_use1  = b1.i_HSB_use1;
    assign b2.i_HSB_flush = b1.i_HSB_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // In-flight writes, index 0 = youngest (EXE).
    typedef struct {
        bit v;
        bit we;
        int wa;
        int lat;
    } ment_t;

    ment_t m [$];
    int    mc  = 0;
    int    mc2 = 0;
    bit    last_st = 0;

    function automatic void mreset();
        ment_t b;
        b = '{v: 0, we: 0, wa: 0, lat: 0};
        m.delete();
        for (int k = 0; k < DEPTH; k++) m.push_back(b);
        mc  = 0;
        mc2 = 0;
    endfunction

    function automatic void mlook(input int ra, input bit u,
                                  output int f, output bit h);
        f = 0;
        h = 0;
        if (!u || ra == 0) return;
        for (int k = 0; k < m.size(); k++) begin
            if (m[k].v && m[k].we && m[k].wa == ra) begin
                if (k >= m[k].lat) f = k + 1;
                else h = 1;
                return;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drv(input bit is, input bit we, input int wa, input int lat,
                       input int ra0, input bit u0, input int ra1, input bit u1,
                       input bit fl);
        b1.i_HSB_issue = is;
        b1.i_HSB_we    = we;
        b1.i_HSB_wa    = 5'(wa);
        b1.i_HSB_lat   = 2'(lat);
        b1.i_HSB_ra0   = 5'(ra0);
        b1.i_HSB_use0  = u0;
        b1.i_HSB_ra1   = 5'(ra1);
        b1.i_HSB_use1  = u1;
        b1.i_HSB_flush = fl;
    endtask

    // Check one cycle against the model, then clock it.
    task automatic cyc();
        int    f0, f1, vb;
        bit    h0, h1, st;
        ment_t e;
        #1;
        mlook(int'(b1.i_HSB_ra0), b1.i_HSB_use0, f0, h0);
        mlook(int'(b1.i_HSB_ra1), b1.i_HSB_use1, f1, h1);
        st = b1.i_HSB_issue && !b1.i_HSB_flush && (h0 || h1);
        vb = 0;
        for (int k = 0; k < DEPTH; k++) if (m[k].v) vb += (1 << k);
        chk("stall", b1.o_HSB_stall, int'(st));
        chk("fwd0", b1.o_HSB_fwd0, f0);
        chk("fwd1", b1.o_HSB_fwd1, f1);
        chk("vld", b1.o_HSB_vld, vb);
        chk("cnt", b1.o_HSB_stall_cnt, mc);
        chk("stall2", b2.o_HSB_stall, int'(st));
        chk("cnt2", b2.o_HSB_stall_cnt, mc2);
        last_st = st;
        @(posedge clk);
        if (!rstn) begin
            mreset();
        end else begin
            e.v   = b1.i_HSB_issue && !st && !b1.i_HSB_flush;
            e.we  = b1.i_HSB_we;
            e.wa  = int'(b1.i_HSB_wa);
            e.lat = (int'(b1.i_HSB_lat) >= DEPTH) ? DEPTH - 1 : int'(b1.i_HSB_lat);
            m.push_front(e);
            void'(m.pop_back());
            if (st) begin
                if (mc < 65535) mc++;
                if (mc2 < 3) mc2++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        mreset();
        drv(1, 1, 7, 1, 7, 1, 7, 1, 0);
        #1;
        chk("rst_vld", b1.o_HSB_vld, 0);
        chk("rst_cnt", b1.o_HSB_stall_cnt, 0);
        chk("rst_stall", b1.o_HSB_stall, 0);
        cyc();
        cyc();
        rstn = 1'b1;

        // ALU back-to-back
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 5, 1, 0, 0, 0);
        #1 chk("alu_fwd_e0", b1.o_HSB_fwd0, 1);
        cyc();
        #1 chk("alu_fwd_e1", b1.o_HSB_fwd0, 2);
        cyc();

        // Load-use
        drv(1, 1, 7, 1, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0);
        #1 chk("lu_stall", b1.o_HSB_stall, 1);
        chk("lu_vld", b1.o_HSB_vld, 1);
        cyc();
        #1 chk("lu_fwd", b1.o_HSB_fwd1, 2);
        chk("lu_nostall", b1.o_HSB_stall, 0);
        chk("lu_cnt", b1.o_HSB_stall_cnt, 1);
        cyc();

        // Youngest priority
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        drv(0, 0, 0, 0, 3, 1, 0, 0, 0);
        #1 chk("young_fwd", b1.o_HSB_fwd0, 1);
        cyc();

        // Unused source ignores a pending load
        drv(1, 1, 4, 1, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 4, 0, 0);
        #1 chk("unused_stall", b1.o_HSB_stall, 0);
        chk("unused_fwd", b1.o_HSB_fwd1, 0);
        cyc();

        // Register zero
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1 chk("zero_fwd", b1.o_HSB_fwd0, 0);
        chk("zero_stall", b1.o_HSB_stall, 0);
        cyc();

        // Flush beats hazard
        drv(1, 1, 7, 1, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 7, 1, 0, 0, 1);
        #1 chk("fl_stall", b1.o_HSB_stall, 0);
        cyc();
        #1 chk("fl_vld0", b1.o_HSB_vld[0], 0);
        chk("fl_vld1", b1.o_HSB_vld[1], 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Two lat=2 hazards: 4 stall cycles
        repeat (2) begin
            drv(1, 1, 9, 2, 0, 0, 0, 0, 0);
            cyc();
            drv(1, 0, 0, 0, 9, 1, 0, 0, 0);
            cyc();
            cyc();
            #1 chk("lat2_fwd", b1.o_HSB_fwd0, 3);
            cyc();
        end
        #1 chk("sat_cnt16", b1.o_HSB_stall_cnt, 5);
        chk("sat_cnt2", b2.o_HSB_stall_cnt, 3);

        // Random traffic; decode inputs held while stalled
        repeat (300) begin
            if (!last_st) begin
                drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0, 0);
            end
            b1.i_HSB_flush = ($urandom_range(0, 7) == 0);
            cyc();
        end

        // Async reset between edges while a hazard is pending
        drv(1, 1, 7, 1, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 1, 6, 0, 7, 1, 7, 1, 0);
        #2 rstn = 1'b0;
        mreset();
        #1 chk("arst_vld", b1.o_HSB_vld, 0);
        chk("arst_cnt", b1.o_HSB_stall_cnt, 0);
        chk("arst_stall", b1.o_HSB_stall, 0);
        chk("arst_fwd0", b1.o_HSB_fwd0, 0);
        chk("arst_fwd1", b1.o_HSB_fwd1, 0);
        cyc();
        rstn = 1'b1;
        cyc();
        drv(0, 0, 0, 0, 6, 1, 0, 0, 0);
        #1 chk("post_rst_fwd", b1.o_HSB_fwd0, 1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
